// File: rtl/select_conditioner.sv
// Front-end conditioning for the two selection pushbuttons and the wave/frequency
// switches: synchronize, debounce, detect presses, and gate them by system state.
module select_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       btn_signal_raw,
  input  logic       btn_freq_raw,
  input  logic [1:0] sw_wave,
  input  logic [3:0] sw_freq,
  input  logic [2:0] state_in,
  output logic       signal_select,
  output logic       freq_select,
  output logic [1:0] wave_sel,
  output logic [3:0] freq_code,
  output logic       sel_reject
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]     ST_SIGNAL = 3'd1;
  localparam logic [2:0]     ST_FREQ   = 3'd3;
  localparam int             BTN_SIG   = 0;
  localparam int             BTN_FREQ  = 1;

  // Bit BTN_SIG tracks the signal button, bit BTN_FREQ the frequency button.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    press;
  logic          sig_ok, freq_ok, reject;

  logic          signal_select_q, freq_select_q, sel_reject_q;
  logic [1:0]    wave_sel_q, wave_sel_d;
  logic [3:0]    freq_code_q, freq_code_d;

  // NOTE: every always_comb output gets a default first, otherwise paths that
  // skip an assignment infer a latch.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b] = deb_q[b];
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          deb_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    press       = deb_q & ~deb_prev_q;
    sig_ok      = press[BTN_SIG] && (state_in == ST_SIGNAL);
    freq_ok     = press[BTN_FREQ] && (state_in == ST_FREQ) && (sw_freq != 4'd0);
    reject      = (press[BTN_SIG] && !sig_ok) || (press[BTN_FREQ] && !freq_ok);
    wave_sel_d  = sig_ok  ? sw_wave : wave_sel_q;
    freq_code_d = freq_ok ? sw_freq : freq_code_q;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its neighbours (the synchronizer chain depends on this).
  // Small arrays like the counters are reset explicitly; a stale count would
  // otherwise survive reset and shorten the next debounce.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      deb_q           <= '0;
      deb_prev_q      <= '0;
      cnt_q[0]        <= '0;
      cnt_q[1]        <= '0;
      signal_select_q <= 1'b0;
      freq_select_q   <= 1'b0;
      sel_reject_q    <= 1'b0;
      wave_sel_q      <= 2'd0;
      freq_code_q     <= 4'd1;
    end else begin
      sync1_q         <= {btn_freq_raw, btn_signal_raw};
      sync2_q         <= sync1_q;
      deb_q           <= deb_d;
      deb_prev_q      <= deb_q;
      cnt_q[0]        <= cnt_d[0];
      cnt_q[1]        <= cnt_d[1];
      signal_select_q <= sig_ok;
      freq_select_q   <= freq_ok;
      sel_reject_q    <= reject;
      wave_sel_q      <= wave_sel_d;
      freq_code_q     <= freq_code_d;
    end
  end

  assign signal_select = signal_select_q;
  assign freq_select   = freq_select_q;
  assign sel_reject    = sel_reject_q;
  assign wave_sel      = wave_sel_q;
  assign freq_code     = freq_code_q;

endmodule

// File: tb/tb_select_conditioner.sv
// Self-checking bench for select_conditioner: directed vector table, multi-cycle
// corner sequences, and randomized stimulus against a sliding-window reference model.
module tb_select_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_signal_raw, btn_freq_raw;
  logic [1:0] sw_wave;
  logic [3:0] sw_freq;
  logic [2:0] state_in;
  logic       signal_select, freq_select, sel_reject;
  logic [1:0] wave_sel;
  logic [3:0] freq_code;

  int checks = 0;
  int errors = 0;

  select_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk_1MHz      (clk),
    .rst_n         (rst_n),
    .btn_signal_raw(btn_signal_raw),
    .btn_freq_raw  (btn_freq_raw),
    .sw_wave       (sw_wave),
    .sw_freq       (sw_freq),
    .state_in      (state_in),
    .signal_select (signal_select),
    .freq_select   (freq_select),
    .wave_sel      (wave_sel),
    .freq_code     (freq_code),
    .sel_reject    (sel_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button's debounced level flips once the last DEB
  // synchronized samples (raw delayed by two edges) all disagree with it.
  logic [1:0] hist [$];
  logic [1:0] m_deb, m_pend;
  logic       m_sig, m_frq, m_rej;
  logic [1:0] m_wave;
  logic [3:0] m_code;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= DEB; k++) hist.push_back(2'b00);
    m_deb = '0; m_pend = '0;
    m_sig = 1'b0; m_frq = 1'b0; m_rej = 1'b0;
    m_wave = 2'd0; m_code = 4'd1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_sig = m_pend[0] && (state_in == 3'd1);
        m_frq = m_pend[1] && (state_in == 3'd3) && (sw_freq != 4'd0);
        m_rej = (m_pend[0] && !m_sig) || (m_pend[1] && !m_frq);
        if (m_sig) m_wave = sw_wave;
        if (m_frq) m_code = sw_freq;
        for (int b = 0; b < 2; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
          m_pend[b] = 1'b0;
          if (all_diff) begin
            m_deb[b]  = ~m_deb[b];
            m_pend[b] = m_deb[b];
          end
        end
        hist.push_back({btn_freq_raw, btn_signal_raw});
        void'(hist.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_signal_select", 8'(signal_select), 8'(m_sig));
    check("mdl_freq_select",   8'(freq_select),   8'(m_frq));
    check("mdl_sel_reject",    8'(sel_reject),    8'(m_rej));
    check("mdl_wave_sel",      8'(wave_sel),      8'(m_wave));
    check("mdl_freq_code",     8'(freq_code),     8'(m_code));
  end

  typedef struct {
    logic       sb, fb;
    logic [2:0] st;
    logic [1:0] wv;
    logic [3:0] fq;
    logic       e_sig, e_frq, e_rej;
    logic [1:0] e_wave;
    logic [3:0] e_code;
  } vec_t;

  vec_t vecs [9];

  task automatic watch(input int which, input int edges, output int first, output int cnt);
    logic p;
    first = 0; cnt = 0;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk); #1;
      p = (which == 0) ? signal_select : (which == 1) ? freq_select : sel_reject;
      if (p) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    state_in = v.st; sw_wave = v.wv; sw_freq = v.fq;
    btn_signal_raw = v.sb; btn_freq_raw = v.fb;
    repeat (DEB + 2) @(posedge clk);
    #1;
    check($sformatf("v%0d_early_pulses", idx),
          8'({signal_select, freq_select, sel_reject}), 8'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d_signal_select", idx), 8'(signal_select), 8'(v.e_sig));
    check($sformatf("v%0d_freq_select", idx),   8'(freq_select),   8'(v.e_frq));
    check($sformatf("v%0d_sel_reject", idx),    8'(sel_reject),    8'(v.e_rej));
    check($sformatf("v%0d_wave_sel", idx),      8'(wave_sel),      8'(v.e_wave));
    check($sformatf("v%0d_freq_code", idx),     8'(freq_code),     8'(v.e_code));
    @(posedge clk); #1;
    check($sformatf("v%0d_one_cycle", idx),
          8'({signal_select, freq_select, sel_reject}), 8'd0);
    @(negedge clk);
    btn_signal_raw = 1'b0; btn_freq_raw = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    int first, cnt, run_s, run_f;

    rst_n = 1'b0;
    btn_signal_raw = 1'b0; btn_freq_raw = 1'b0;
    sw_wave = 2'd0; sw_freq = 4'd0; state_in = 3'd0;

    vecs[0] = '{1'b1, 1'b0, 3'd1, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd1};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd1};
    vecs[2] = '{1'b0, 1'b1, 3'd3, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0, 2'd2, 4'd9};
    vecs[3] = '{1'b1, 1'b0, 3'd0, 2'd3, 4'd2, 1'b0, 1'b0, 1'b1, 2'd2, 4'd9};
    vecs[4] = '{1'b1, 1'b0, 3'd5, 2'd3, 4'd2, 1'b0, 1'b0, 1'b1, 2'd2, 4'd9};
    vecs[5] = '{1'b0, 1'b1, 3'd1, 2'd0, 4'd7, 1'b0, 1'b0, 1'b1, 2'd2, 4'd9};
    vecs[6] = '{1'b1, 1'b1, 3'd1, 2'd1, 4'd6, 1'b1, 1'b0, 1'b1, 2'd1, 4'd9};
    vecs[7] = '{1'b1, 1'b1, 3'd3, 2'd3, 4'd5, 1'b0, 1'b1, 1'b1, 2'd1, 4'd5};
    vecs[8] = '{1'b1, 1'b0, 3'd1, 2'd3, 4'd5, 1'b1, 1'b0, 1'b0, 2'd3, 4'd5};

    repeat (3) @(negedge clk);
    check("rst_signal_select", 8'(signal_select), 8'd0);
    check("rst_freq_select",   8'(freq_select),   8'd0);
    check("rst_sel_reject",    8'(sel_reject),    8'd0);
    check("rst_wave_sel",      8'(wave_sel),      8'd0);
    check("rst_freq_code",     8'(freq_code),     8'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Bouncing frequency press: 1,0,1,0 then steady high.
    @(negedge clk);
    state_in = 3'd3; sw_freq = 4'd9;
    btn_freq_raw = 1'b1; @(negedge clk);
    btn_freq_raw = 1'b0; @(negedge clk);
    btn_freq_raw = 1'b1; @(negedge clk);
    btn_freq_raw = 1'b0; @(negedge clk);
    btn_freq_raw = 1'b1;
    watch(1, 12, first, cnt);
    check("bounce_pulse_count", 8'(cnt), 8'd1);
    check("bounce_pulse_edge", 8'(first), 8'(DEB + 3));
    check("bounce_freq_code", 8'(freq_code), 8'd9);
    @(negedge clk); btn_freq_raw = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    // Reset asserted at edge 3 of a press.
    state_in = 3'd1; sw_wave = 2'd1; btn_signal_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wave_sel",  8'(wave_sel),  8'd0);
    check("midrst_freq_code", 8'(freq_code), 8'd1);
    check("midrst_pulses", 8'({signal_select, freq_select, sel_reject}), 8'd0);
    @(negedge clk); btn_signal_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(0, 15, first, cnt);
    check("midrst_no_pulse", 8'(cnt), 8'd0);

    // Button held through reset release.
    @(negedge clk);
    btn_signal_raw = 1'b1; sw_wave = 2'd3;
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch(0, 12, first, cnt);
    check("heldrst_pulse_count", 8'(cnt), 8'd1);
    check("heldrst_pulse_edge", 8'(first), 8'(DEB + 3));
    check("heldrst_wave_sel", 8'(wave_sel), 8'd3);

    // Long hold: stays high (already high) for 100 more cycles, no re-press.
    watch(0, 100, first, cnt);
    check("hold_no_repeat", 8'(cnt), 8'd0);
    @(negedge clk); btn_signal_raw = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    btn_signal_raw = 1'b1; sw_wave = 2'd2;
    watch(0, 100, first, cnt);
    check("hold_pulse_count", 8'(cnt), 8'd1);
    check("hold_wave_sel", 8'(wave_sel), 8'd2);
    @(negedge clk); btn_signal_raw = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    // Random stimulus, checked by the model every cycle.
    run_s = 0; run_f = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (run_s == 0) begin
        btn_signal_raw = 1'($urandom_range(0, 1));
        run_s = $urandom_range(1, 9);
      end else run_s--;
      if (run_f == 0) begin
        btn_freq_raw = 1'($urandom_range(0, 1));
        run_f = $urandom_range(1, 9);
      end else run_f--;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: state_in = 3'd0;
          1: state_in = 3'd1;
          2: state_in = 3'd3;
          default: state_in = 3'd5;
        endcase
        sw_wave = 2'($urandom_range(0, 3));
        sw_freq = 4'($urandom_range(0, 15));
      end
      if (i == 1500) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_conditioner.md
SELECT_CONDITIONER -- requirements
Module: select_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, the number of consecutive stable cycles (20 ms at 1 MHz) needed to accept a level change.
REQ-002 SHALL have port clk_1MHz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port btn_signal_raw, input, 1 bit: raw, asynchronous, bouncing signal-select pushbutton, active high.
REQ-005 SHALL have port btn_freq_raw, input, 1 bit: raw, asynchronous, bouncing frequency-select pushbutton, active high.
REQ-006 SHALL have port sw_wave, input, 2 bits: waveform-choice switches, quasi-static.
REQ-007 SHALL have port sw_freq, input, 4 bits: frequency-code switches, quasi-static.
REQ-008 SHALL have port state_in, input, 3 bits: current state code from the system state machine.
REQ-009 SHALL have port signal_select, output, 1 bit: one-cycle accepted signal-select pulse.
REQ-010 SHALL have port freq_select, output, 1 bit: one-cycle accepted frequency-select pulse.
REQ-011 SHALL have port wave_sel, output, 2 bits: latched waveform choice.
REQ-012 SHALL have port freq_code, output, 4 bits: latched frequency code.
REQ-013 SHALL have port sel_reject, output, 1 bit: one-cycle pulse when a debounced press is not accepted.

Function
REQ-014 SHALL pass each raw button through its own 2-flop synchronizer; no other logic SHALL sample the raw inputs.
REQ-015 SHALL keep, per button, a debounced level and a counter of width clog2(DEBOUNCE_CYCLES)+1.
- Counter clears whenever the synchronized input equals the debounced level.
- Otherwise the counter increments each cycle.
- When it would reach DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
REQ-016 SHALL detect a press as a 0->1 transition of a debounced level; releases (1->0) SHALL generate no pulse.
REQ-017 SHALL define press-to-pulse latency as exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples raw high, given a bounce-free input.
REQ-018 SHALL treat any raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles as no change, restarting the count.
REQ-019 SHALL handle a signal-button press as follows:
- If state_in==3'd1 (signal-select state): assert signal_select for one cycle and load wave_sel<=sw_wave on the same edge.
- Otherwise: assert sel_reject for one cycle.
REQ-020 SHALL handle a frequency-button press as follows:
- If state_in==3'd3 and sw_freq!=0: assert freq_select for one cycle and load freq_code<=sw_freq on the same edge.
- Otherwise, including sw_freq==0: assert sel_reject for one cycle and leave freq_code unchanged.
REQ-021 SHALL evaluate simultaneous presses on both buttons independently; sel_reject SHALL assert once if either press is rejected.
REQ-022 SHALL hold wave_sel and freq_code between accepted presses, regardless of state_in changes.
REQ-023 SHALL register all outputs, with no combinational path from any input to any output.
REQ-024 SHALL produce a held button exactly one pulse; re-press requires a debounced release first.

Reset
REQ-025 SHALL, while rst_n==0, asynchronously force the following; synchronizers, debounced levels and counters clear at the same time:
- signal_select, freq_select and sel_reject to 0.
- wave_sel to 2'd0.
- freq_code to 4'd1.
REQ-026 SHALL, for a button held through reset release, register one press DEBOUNCE_CYCLES+3 edges after release.
REQ-027 SHALL discard any in-progress debounce count on reset assertion mid-operation, with no pulse emitted.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 SHALL cover a clean signal press: state_in=1, sw_wave=2, btn_signal_raw rises.
- Required: signal_select high for exactly 1 cycle at edge 7, and wave_sel=2 from that edge.
REQ-029 SHALL cover a bounce: btn_freq_raw toggles 1,0,1,0 each cycle, then stays high, with state_in=3 and sw_freq=9.
- Required: a single freq_select pulse 7 edges after the final rise, and freq_code=9.
REQ-030 SHALL cover wrong-state presses: press in state_in=0, then in state_in=5.
- Required: sel_reject pulses twice, with no select pulses and no latch changes.
REQ-031 SHALL cover a zero frequency code: state_in=3, sw_freq=0, press.
- Required: sel_reject for 1 cycle, freq_code stays 1.
REQ-032 SHALL cover reset mid-debounce: rst_n low at edge 3 of a press.
- Required: outputs at reset values immediately; no pulse from the interrupted press.
REQ-033 SHALL cover a long hold: button held 100 cycles in state_in=1.
- Required: exactly one signal_select pulse.
